bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-port arbiter that shares one external memory bus between instruction fetch and the MEM-stage load/store path of the 5-stage pipeline. It serialises the two requesters onto a single classic-cycle bus (cyc/stb/ack) with MEM-stage priority. It registers read data back to the winner and raises a stall request toward `ctrl` while any requester is waiting. It also retires hung bus cycles with a timeout.

## Interface
Parameters:
- TIMEOUT, 255: bus cycles allowed in a BUSY state before forced termination; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held high, with address stable, until `if_ack_o`.
- if_addr_i  in  32  fetch address.
- if_rdata_o  out  32  fetched instruction; valid while `if_ack_o` is high.
- if_ack_o  out  1  one-cycle completion pulse for fetch.
- flush_i  in  1  pipeline flush; cancels delivery of any pending fetch.
- mem_req_i  in  1  data request; held high until `mem_ack_o`.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_sel_i  in  4  byte lane enables.
- mem_addr_i  in  32  data address.
- mem_wdata_i  in  32  store data.
- mem_rdata_o  out  32  load data; valid while `mem_ack_o` is high.
- mem_ack_o  out  1  one-cycle completion pulse for data.
- bus_cyc_o, bus_stb_o  out  1  bus cycle / strobe; always equal.
- bus_we_o  out  1  bus write enable.
- bus_sel_o  out  4  bus byte lanes; fetch drives 4'b1111.
- bus_addr_o  out  32  bus address.
- bus_wdata_o  out  32  bus write data; 0 for fetch.
- bus_rdata_i  in  32  bus read data.
- bus_ack_i  in  1  bus acknowledge.
- err_o  out  1  one-cycle pulse when a cycle terminates by timeout.
- stallreq_o  out  1  stall request to `ctrl`.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_MEM, DONE.
- IDLE:
  - `mem_req_i` → BUSY_MEM.
  - Else `if_req_i` → BUSY_IF.
  - Fixed priority; MEM wins simultaneous requests.
  - On the transition edge, register the winner's address, we, sel and wdata onto the bus outputs, set cyc/stb = 1, and clear the timeout counter.
- BUSY_x:
  - Bus outputs are held constant.
  - `bus_ack_i` = 1 → capture `bus_rdata_i` into the winner's rdata register, drop cyc/stb, → DONE.
  - Counter reaches TIMEOUT without ack → drop cyc/stb, load rdata = 0, pulse `err_o`, → DONE.
  - Counter is 8-bit and saturating.
- DONE:
  - Winner's ack is high for exactly this cycle, then → IDLE.
  - Requests are sampled only in IDLE.
  - A requester that keeps req high after its ack is treated as a new request.
- Flush:
  - `flush_i` high in any cycle while BUSY_IF, or in the transition into it, sets a cancel flag.
  - The bus cycle still runs to ack or timeout; it is never aborted mid-cycle.
  - With the cancel flag set, `if_ack_o` stays 0 in DONE and `if_rdata_o` is not updated.
  - `flush_i` in DONE(IF) forces `if_ack_o` = 0 that cycle.
  - `flush_i` has no effect on MEM transactions.
- `stallreq_o` (combinational): (`if_req_i` & ~`if_ack_o`) | (`mem_req_i` & ~`mem_ack_o`).
- `bus_ack_i` outside BUSY states is ignored.
- Reset (asynchronous, any state, including mid-bus-cycle):
  - FSM → IDLE.
  - cyc/stb/we/ack/err = 0; sel, addr, wdata, rdata = 0.
  - Cancel flag and counter cleared.
  - The bus slave must tolerate cyc dropping without ack.

## Timing
- All outputs except `stallreq_o` are registered.
- Zero-wait-state slave (ack in the first BUSY cycle):
  - req seen in IDLE at cycle 0 → cyc high in cycle 1 → ack_o high in cycle 2 → IDLE in cycle 3.
  - 3 cycles per access minimum; back-to-back same-requester accesses every 3 cycles.
- Slave with w wait states: ack_o in cycle 2+w.
- Timeout: cyc high for cycles 1..TIMEOUT; `err_o` and ack_o high in cycle TIMEOUT+1.
- With both requesters pending at cycle 0: MEM ack in cycle 2, IF bus cycle starts in cycle 4, IF ack in cycle 5.

## Test plan
- Single fetch, 0 wait states, addr 0x0000_0100, slave data 0x3401_1100:
  - bus_addr_o = 0x100, sel = 4'hF, we = 0 in cycle 1.
  - `if_ack_o` = 1 and `if_rdata_o` = 0x3401_1100 in cycle 2.
  - `stallreq_o` high in cycles 0–1.
- Simultaneous requests (fetch 0x104; store 0xDEAD_BEEF, sel 4'b0011, to 0x2000):
  - Store is issued first with we = 1, sel = 4'b0011.
  - `mem_ack_o` in cycle 2; fetch cyc in cycle 4; `if_ack_o` in cycle 5.
- Slave with 3 wait states on a load from 0x2004:
  - Bus outputs stable for cycles 1–4.
  - `mem_ack_o` in cycle 5 with the slave data.
- Slave never acks, TIMEOUT = 4:
  - cyc high for cycles 1–4.
  - In cycle 5: `err_o` = 1, `mem_ack_o` = 1, `mem_rdata_o` = 0.
  - FSM back in IDLE in cycle 6.
- `flush_i` pulsed in cycle 2 of a 2-wait-state fetch:
  - Bus cycle completes.
  - `if_ack_o` never asserts; `if_rdata_o` retains its old value.
  - A subsequent fetch completes normally.
- `rst` asserted low mid-BUSY_MEM:
  - cyc, stb, ack and err go 0 immediately, without waiting for a clock edge.
  - After release, the next request starts from IDLE with cycle-1 bus issue.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one classic-cycle (cyc/stb/ack) memory bus between the
// instruction-fetch port and the MEM-stage load/store port. MEM has fixed priority.
//
// Latency: request seen in IDLE at cycle 0 -> bus cycle from cycle 1 -> ack_o in
//   cycle 2+w (w = slave wait states) -> IDLE again the cycle after. Minimum 3 cycles per access.
// Backpressure: a requester holds req (and its address) until its ack. stallreq_o
//   asks ctrl to freeze the pipe while either request is still outstanding.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   if_req_i/if_addr_i           fetch request (read-only, full-word)
//   if_rdata_o/if_ack_o          fetch data and one-cycle completion pulse
//   flush_i                      cancels delivery of an in-flight fetch
//   mem_req_i/we/sel/addr/wdata  load/store request
//   mem_rdata_o/mem_ack_o        load data and one-cycle completion pulse
//   bus_*                        external classic-cycle bus master port
//   err_o                        one-cycle pulse when a bus cycle ends by timeout
//   stallreq_o                   combinational stall request to ctrl
module bus_arbiter #(
  parameter int TIMEOUT = 255  // BUSY cycles allowed before forced termination, 1..255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        flush_i,

  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,

  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,

  output logic        err_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUSY_IF  = 2'd1,
    S_BUSY_MEM = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  // The counter holds the number of BUSY cycles already completed, so the
  // cycle in which it equals TIMEOUT-1 is the last one the slave is allowed.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;

  logic        cyc_q,       cyc_d;
  logic        we_q,        we_d;
  logic [3:0]  sel_q,       sel_d;
  logic [31:0] addr_q,      addr_d;
  logic [31:0] wdata_q,     wdata_d;
  logic [31:0] if_rdata_q,  if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_ack_q,    if_ack_d;
  logic        mem_ack_q,   mem_ack_d;
  logic        err_q,       err_d;
  logic        cancel_q,    cancel_d;
  logic [7:0]  cnt_q,       cnt_d;

  logic        busy;
  logic        to_hit;
  logic        finish;
  logic        if_drop;
  logic [31:0] fin_rdata;

  assign busy      = (state_q == S_BUSY_IF) || (state_q == S_BUSY_MEM);
  assign to_hit    = (cnt_q == TO_LAST);
  // Slave ack wins over a coincident timeout: the data is real.
  assign finish    = busy && (bus_ack_i || to_hit);
  assign fin_rdata = bus_ack_i ? bus_rdata_i : 32'h0;
  // A fetch is dropped if it was flushed earlier or is flushed this very cycle.
  assign if_drop   = cancel_q || flush_i;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Requests are only looked at in IDLE, so a requester that
  // keeps req high through DONE is simply re-arbitrated as a new access.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req_i) begin
          state_d = S_BUSY_MEM;
        end else if (if_req_i) begin
          state_d = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_MEM: begin
        if (finish) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values for the registered bus/response outputs.
  // Bus fields default to holding, so they stay constant through BUSY.
  // ---------------------------------------------------------------------------
  always_comb begin
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    err_d       = 1'b0;
    cancel_d    = cancel_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        cancel_d = 1'b0;
        if (mem_req_i) begin
          cyc_d   = 1'b1;
          we_d    = mem_we_i;
          sel_d   = mem_sel_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          cnt_d   = 8'h0;
        end else if (if_req_i) begin
          cyc_d    = 1'b1;
          we_d     = 1'b0;
          sel_d    = 4'hF;
          addr_d   = if_addr_i;
          wdata_d  = 32'h0;
          cnt_d    = 8'h0;
          // A flush on the launch edge already kills this fetch.
          cancel_d = flush_i;
        end
      end

      S_BUSY_IF: begin
        cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        cancel_d = if_drop;
        if (finish) begin
          cyc_d = 1'b0;
          err_d = ~bus_ack_i;
          // A cancelled fetch still finishes on the bus, but nothing is
          // delivered: no ack and the previous instruction word is kept.
          if (!if_drop) begin
            if_ack_d   = 1'b1;
            if_rdata_d = fin_rdata;
          end
        end
      end

      S_BUSY_MEM: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (finish) begin
          cyc_d       = 1'b0;
          err_d       = ~bus_ack_i;
          mem_ack_d   = 1'b1;
          mem_rdata_d = fin_rdata;
        end
      end

      S_DONE: begin
        // ack/err pulses fall back to 0 via the defaults.
      end

      default: begin
        cyc_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      cancel_q    <= 1'b0;
      cnt_q       <= 8'h0;
    end else begin
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      err_q       <= err_d;
      cancel_q    <= cancel_d;
      cnt_q       <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_cyc_o   = cyc_q;
  assign bus_stb_o   = cyc_q;
  assign bus_we_o    = we_q;
  assign bus_sel_o   = sel_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_ack_o   = mem_ack_q;
  assign err_o       = err_q;

  // A flush arriving in the DONE cycle itself must still squash the fetch
  // ack, so this one output gets a combinational gate after its register.
  assign if_ack_o    = if_ack_q & ~flush_i;

  assign stallreq_o  = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of bus_arbiter against hand-computed vectors.
// Latency: counts cycles from the IDLE cycle a request is presented (cycle 0).
// Backpressure: a simple bus slave model with programmable wait states / mute.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = 32'h0;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        flush_i = 1'b0;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_sel_i = 4'h0;
  logic [31:0] mem_addr_i = 32'h0;
  logic [31:0] mem_wdata_i = 32'h0;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i = 32'h0;
  logic        bus_ack_i = 1'b0;
  logic        err_o;
  logic        stallreq_o;

  int          n_vec = 0;
  int          n_bad = 0;

  int          slave_ws = 0;
  logic        slave_mute = 1'b0;
  logic [31:0] slave_data = 32'h0;

  bus_arbiter #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ack_o    (if_ack_o),
    .flush_i     (flush_i),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_sel_i   (mem_sel_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_ack_o   (mem_ack_o),
    .bus_cyc_o   (bus_cyc_o),
    .bus_stb_o   (bus_stb_o),
    .bus_we_o    (bus_we_o),
    .bus_sel_o   (bus_sel_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i),
    .err_o       (err_o),
    .stallreq_o  (stallreq_o)
  );

  always #5 clk = ~clk;

  // Bus slave: acks in the (slave_ws+1)-th cycle that cyc is seen high.
  always @(posedge clk) begin
    int ws_cnt;
    #2;
    if (bus_cyc_o && !slave_mute) begin
      if (ws_cnt == slave_ws) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = slave_data;
        ws_cnt      = 0;
      end else begin
        bus_ack_i = 1'b0;
        ws_cnt    = ws_cnt + 1;
      end
    end else begin
      bus_ack_i = 1'b0;
      ws_cnt    = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Move to the start of the next cycle (just after the rising edge).
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Sample point inside the current cycle.
  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    smp();
    check("rst_cyc",   32'(bus_cyc_o), 0);
    check("rst_stb",   32'(bus_stb_o), 0);
    check("rst_we",    32'(bus_we_o), 0);
    check("rst_sel",   32'(bus_sel_o), 0);
    check("rst_addr",  bus_addr_o, 0);
    check("rst_ifack", 32'(if_ack_o), 0);
    check("rst_mack",  32'(mem_ack_o), 0);
    check("rst_err",   32'(err_o), 0);
    #1 rst = 1'b1;

    // ---------------- single fetch, 0 wait states ----------------
    adv();  // cycle 0
    slave_ws = 0; slave_data = 32'h3401_1100;
    if_addr_i = 32'h0000_0100; if_req_i = 1'b1;
    smp();
    check("f1_c0_stall", 32'(stallreq_o), 1);
    check("f1_c0_cyc",   32'(bus_cyc_o), 0);
    adv(); smp();  // cycle 1
    check("f1_c1_cyc",   32'(bus_cyc_o), 1);
    check("f1_c1_stb",   32'(bus_stb_o), 1);
    check("f1_c1_addr",  bus_addr_o, 32'h100);
    check("f1_c1_sel",   32'(bus_sel_o), 32'hF);
    check("f1_c1_we",    32'(bus_we_o), 0);
    check("f1_c1_stall", 32'(stallreq_o), 1);
    check("f1_c1_ack",   32'(if_ack_o), 0);
    adv(); smp();  // cycle 2
    check("f1_c2_ack",   32'(if_ack_o), 1);
    check("f1_c2_rdata", if_rdata_o, 32'h3401_1100);
    check("f1_c2_stall", 32'(stallreq_o), 0);
    check("f1_c2_cyc",   32'(bus_cyc_o), 0);
    adv(); if_req_i = 1'b0; smp();  // cycle 3
    check("f1_c3_ack",   32'(if_ack_o), 0);

    // ---------------- simultaneous requests ----------------
    adv();  // cycle 0
    slave_ws = 0; slave_data = 32'h1111_2222;
    if_addr_i = 32'h104; if_req_i = 1'b1;
    mem_addr_i = 32'h2000; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
    mem_wdata_i = 32'hDEAD_BEEF; mem_req_i = 1'b1;
    adv(); smp();  // cycle 1
    check("sim_c1_cyc",   32'(bus_cyc_o), 1);
    check("sim_c1_we",    32'(bus_we_o), 1);
    check("sim_c1_sel",   32'(bus_sel_o), 32'h3);
    check("sim_c1_addr",  bus_addr_o, 32'h2000);
    check("sim_c1_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    adv(); smp();  // cycle 2
    check("sim_c2_mack",  32'(mem_ack_o), 1);
    check("sim_c2_ifack", 32'(if_ack_o), 0);
    adv(); mem_req_i = 1'b0; smp();  // cycle 3
    check("sim_c3_cyc",   32'(bus_cyc_o), 0);
    check("sim_c3_mack",  32'(mem_ack_o), 0);
    adv(); smp();  // cycle 4
    check("sim_c4_cyc",   32'(bus_cyc_o), 1);
    check("sim_c4_addr",  bus_addr_o, 32'h104);
    check("sim_c4_we",    32'(bus_we_o), 0);
    check("sim_c4_sel",   32'(bus_sel_o), 32'hF);
    check("sim_c4_wdata", bus_wdata_o, 32'h0);
    adv(); smp();  // cycle 5
    check("sim_c5_ifack", 32'(if_ack_o), 1);
    check("sim_c5_rdata", if_rdata_o, 32'h1111_2222);
    adv(); if_req_i = 1'b0; smp();  // cycle 6

    // ---------------- load with 3 wait states ----------------
    adv();  // cycle 0
    slave_ws = 3; slave_data = 32'hCAFE_F00D;
    mem_addr_i = 32'h2004; mem_we_i = 1'b0; mem_sel_i = 4'hF;
    mem_wdata_i = 32'h0; mem_req_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      adv(); smp();
      check($sformatf("ws3_c%0d_cyc", c),  32'(bus_cyc_o), 1);
      check($sformatf("ws3_c%0d_addr", c), bus_addr_o, 32'h2004);
      check($sformatf("ws3_c%0d_mack", c), 32'(mem_ack_o), 0);
    end
    adv(); smp();  // cycle 5
    check("ws3_c5_mack",  32'(mem_ack_o), 1);
    check("ws3_c5_rdata", mem_rdata_o, 32'hCAFE_F00D);
    check("ws3_c5_err",   32'(err_o), 0);
    adv(); mem_req_i = 1'b0; smp();  // cycle 6

    // ---------------- timeout (slave never acks, TIMEOUT = 4) ----------------
    adv();  // cycle 0
    slave_mute = 1'b1;
    mem_addr_i = 32'h3000; mem_req_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      adv(); smp();
      check($sformatf("to_c%0d_cyc", c), 32'(bus_cyc_o), 1);
      check($sformatf("to_c%0d_err", c), 32'(err_o), 0);
    end
    adv(); smp();  // cycle 5
    check("to_c5_err",   32'(err_o), 1);
    check("to_c5_mack",  32'(mem_ack_o), 1);
    check("to_c5_rdata", mem_rdata_o, 32'h0);
    check("to_c5_cyc",   32'(bus_cyc_o), 0);
    adv(); mem_req_i = 1'b0; smp();  // cycle 6
    check("to_c6_err",   32'(err_o), 0);
    check("to_c6_mack",  32'(mem_ack_o), 0);
    check("to_c6_cyc",   32'(bus_cyc_o), 0);
    slave_mute = 1'b0;

    // ---------------- flush during a 2-wait-state fetch ----------------
    adv();  // cycle 0
    slave_ws = 2; slave_data = 32'h5555_5555;
    if_addr_i = 32'h200; if_req_i = 1'b1;
    adv(); smp();  // cycle 1
    check("fl_c1_cyc", 32'(bus_cyc_o), 1);
    check("fl_c1_ack", 32'(if_ack_o), 0);
    adv(); flush_i = 1'b1; smp();  // cycle 2
    check("fl_c2_cyc", 32'(bus_cyc_o), 1);
    check("fl_c2_ack", 32'(if_ack_o), 0);
    adv(); flush_i = 1'b0; smp();  // cycle 3: slave acks here
    check("fl_c3_cyc", 32'(bus_cyc_o), 1);
    check("fl_c3_ack", 32'(if_ack_o), 0);
    adv(); smp();  // cycle 4 (DONE)
    check("fl_c4_ack",   32'(if_ack_o), 0);
    check("fl_c4_rdata", if_rdata_o, 32'h1111_2222);
    check("fl_c4_cyc",   32'(bus_cyc_o), 0);
    adv(); if_req_i = 1'b0; smp();  // cycle 5
    check("fl_c5_ack",   32'(if_ack_o), 0);

    // subsequent fetch completes normally
    adv();  // cycle 0
    slave_ws = 0; slave_data = 32'h7777_8888;
    if_addr_i = 32'h204; if_req_i = 1'b1;
    adv(); smp();  // cycle 1
    check("fl2_c1_addr", bus_addr_o, 32'h204);
    adv(); smp();  // cycle 2
    check("fl2_c2_ack",   32'(if_ack_o), 1);
    check("fl2_c2_rdata", if_rdata_o, 32'h7777_8888);
    adv(); if_req_i = 1'b0; smp();

    // flush in the DONE cycle squashes the ack that cycle
    adv();  // cycle 0
    slave_data = 32'h1234_0000;
    if_addr_i = 32'h300; if_req_i = 1'b1;
    adv(); smp();  // cycle 1
    adv(); flush_i = 1'b1; smp();  // cycle 2 (DONE)
    check("fld_c2_ack", 32'(if_ack_o), 0);
    adv(); flush_i = 1'b0; if_req_i = 1'b0; smp();

    // ---------------- reset mid BUSY_MEM ----------------
    adv();  // cycle 0
    slave_mute = 1'b1;
    mem_addr_i = 32'h4000; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_req_i = 1'b1;
    adv(); smp();  // cycle 1
    check("rm_c1_cyc", 32'(bus_cyc_o), 1);
    #1 rst = 1'b0;
    #1;  // still well before the next rising edge
    check("rm_cyc",  32'(bus_cyc_o), 0);
    check("rm_stb",  32'(bus_stb_o), 0);
    check("rm_mack", 32'(mem_ack_o), 0);
    check("rm_err",  32'(err_o), 0);
    check("rm_addr", bus_addr_o, 32'h0);
    adv(); mem_req_i = 1'b0; slave_mute = 1'b0;
    adv(); rst = 1'b1;
    adv();  // cycle 0
    slave_ws = 0; slave_data = 32'h9999_AAAA;
    mem_addr_i = 32'h4008; mem_req_i = 1'b1;
    smp();
    check("rr_c0_cyc", 32'(bus_cyc_o), 0);
    adv(); smp();  // cycle 1
    check("rr_c1_cyc",  32'(bus_cyc_o), 1);
    check("rr_c1_addr", bus_addr_o, 32'h4008);
    adv(); smp();  // cycle 2
    check("rr_c2_mack",  32'(mem_ack_o), 1);
    check("rr_c2_rdata", mem_rdata_o, 32'h9999_AAAA);
    adv(); mem_req_i = 1'b0; smp();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
